counter_sequencer: RTL

Controller that sequences the 8-bit demo counter through a fixed load / count-up / hold / count-down program. It owns the counter's `enable_counter`, `load_preset` and `preset_value` controls and takes the counter value back as feedback. It replaces free-running demo-state stepping with a start-triggered, abortable run that reports its state to the display/LED logic.

---
 rtl/counter_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: drives the 8-bit demo counter through a load / count-up /
// hold / count-down program on request. It can be aborted at any point and
// reports its state to the display/LED logic.
`timescale 1ns/1ps

module counter_sequencer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PRESET_A    = 100,
    parameter int unsigned PRESET_B    = 20,
    parameter int unsigned UP_LIMIT    = 200,
    parameter int unsigned HOLD_CYCLES = 15
) (
    input  logic             clk,
    input  logic             reset_btn,
    input  logic             start,
    input  logic             abort,
    input  logic             mode_switch,
    input  logic [WIDTH-1:0] count_value,
    output logic             enable_counter,
    output logic             up_down,
    output logic             load_preset,
    output logic [WIDTH-1:0] preset_value,
    output logic [3:0]       demo_state,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] StIdle = 4'd0;
    localparam logic [3:0] StLoad = 4'd1;
    localparam logic [3:0] StUp   = 4'd2;
    localparam logic [3:0] StHold = 4'd3;
    localparam logic [3:0] StDown = 4'd4;
    localparam logic [3:0] StDone = 4'd5;

    localparam logic [WIDTH-1:0] PresetAW  = WIDTH'(PRESET_A);
    localparam logic [WIDTH-1:0] PresetBW  = WIDTH'(PRESET_B);
    localparam logic [WIDTH-1:0] UpLimitW  = WIDTH'(UP_LIMIT);
    localparam logic [WIDTH-1:0] UpLastW   = WIDTH'(UP_LIMIT - 1);
    localparam logic [WIDTH-1:0] OneW      = WIDTH'(1);
    localparam logic [3:0]       HoldLast  = 4'(HOLD_CYCLES - 1);

    logic [3:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;

    // Next-state logic for the program sequence, with abort overriding everything.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        preset_d = preset_q;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    mode_d   = mode_switch;
                    preset_d = mode_switch ? PresetBW : PresetAW;
                    state_d  = StLoad;
                end
            end
            StLoad: state_d = (preset_q >= UpLimitW) ? StHold : StUp;
            StUp: begin
                // Counter reaches UP_LIMIT on the same edge we leave.
                if (count_value == UpLastW) state_d = StHold;
            end
            StHold: begin
                // Counter is static in HOLD, so a zero here means DOWN would
                // start at 0: skip it rather than take a wrapping step.
                if (hold_cnt_q == HoldLast) begin
                    state_d = (mode_q || count_value == '0) ? StDone : StDown;
                end
            end
            StDown: begin
                if (count_value <= OneW) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && state_q != StIdle) state_d = StIdle;
    end

    // Dwell counter: zero on HOLD entry, counts while staying in HOLD.
    always_comb begin
        hold_cnt_d = 4'd0;
        if (state_q == StHold && state_d == StHold) hold_cnt_d = hold_cnt_q + 4'd1;
    end

    // State registers, asynchronously cleared by the reset button.
    always_ff @(posedge clk or negedge reset_btn) begin
        if (!reset_btn) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            preset_q   <= PresetAW;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            preset_q   <= preset_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Moore decode of counter controls from the registered state.
    always_comb begin
        enable_counter = 1'b0;
        up_down        = 1'b0;
        load_preset    = 1'b0;
        done           = 1'b0;
        case (state_q)
            StLoad: load_preset = 1'b1;
            StUp: begin
                enable_counter = 1'b1;
                up_down        = 1'b1;
            end
            StDown:  enable_counter = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy         = (state_q != StIdle);
    assign demo_state   = state_q;
    assign preset_value = preset_q;

endmodule
